ram_read_stream: RTL and testbench



---
 rtl/ram_read_stream_pkg.sv | 46 ++++
 rtl/ram_read_stream_fwd.sv | 56 +++++
 rtl/ram_read_stream.sv | 120 ++++++++++++
 tb/tb_ram_read_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_read_stream_pkg.sv
// Shared types, constants and the lane-merge helper for the ram_read_stream
// read front-end.
package ram_read_stream_pkg;

    // Response buffer depth; with one read in flight this covers the RAM's
    // single-cycle latency plus one cycle of consumer backpressure.
    localparam int BUF_DEPTH = 2;

    // Occupancy of the response buffer (0..BUF_DEPTH).
    typedef logic [1:0] count_t;

    // Upper bounds for the generic lane-merge helper. Callers zero-extend
    // their operands to these widths and truncate the result back.
    localparam int MERGE_MAX_DATA_W = 256;
    localparam int MERGE_MAX_MASK_W = 32;

    // Replace every lane of 'ram' whose mask bit is set with the matching
    // lane of 'wdata'. Lane 0 occupies the least significant lane_w bits.
    // The mask is walked by shifting so that every select uses a constant
    // bit position after loop unrolling.
    function automatic logic [MERGE_MAX_DATA_W-1:0] merge_lanes(
        input logic [MERGE_MAX_DATA_W-1:0] ram,
        input logic [MERGE_MAX_DATA_W-1:0] wdata,
        input logic [MERGE_MAX_MASK_W-1:0] mask,
        input int                          lane_w
    );
        logic [MERGE_MAX_DATA_W-1:0] res;
        logic [MERGE_MAX_MASK_W-1:0] lane_mask;
        int                          pos;
        res       = ram;
        lane_mask = mask;
        pos       = 0;
        for (int b = 0; b < MERGE_MAX_DATA_W; b++) begin
            if (lane_mask[0]) begin
                res[b] = wdata[b];
            end
            pos = pos + 1;
            if (pos == lane_w) begin
                lane_mask = lane_mask >> 1;
                pos       = 0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_read_stream_fwd.sv
// Write-to-read forwarding for ram_read_stream. Compares the snooped RAM
// write against the read being issued, remembers hit/mask/data for one
// cycle, and merges the written lanes over the RAM read data when that read
// returns. Only instantiated when RAM_READ_STREAM_FORWARD_EN is defined.
module ram_read_stream_fwd
    import ram_read_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fire,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  snoop_wr_en,
    input  logic [MASK_WIDTH-1:0] snoop_wr_mask,
    input  logic [ADDR_WIDTH-1:0] snoop_wr_addr,
    input  logic [DATA_WIDTH-1:0] snoop_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int LANE_W = DATA_WIDTH / MASK_WIDTH;

    logic                  hit;
    logic [MASK_WIDTH-1:0] hit_mask;
    logic [DATA_WIDTH-1:0] hit_data;

    // Hit flag: only a write in the very cycle the read is issued collides;
    // later writes are ordered after the read and must not be merged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit <= 1'b0;
        end else begin
            hit <= fire && snoop_wr_en && (snoop_wr_addr == req_addr);
        end
    end

    // Mask and data payload of the colliding write; qualified by hit, so
    // no reset is needed.
    always_ff @(posedge clk) begin
        if (fire) begin
            hit_mask <= snoop_wr_mask;
            hit_data <= snoop_wr_data;
        end
    end

    assign merged = hit
        ? DATA_WIDTH'(merge_lanes(MERGE_MAX_DATA_W'(ram_rd_data),
                                  MERGE_MAX_DATA_W'(hit_data),
                                  MERGE_MAX_MASK_W'(hit_mask),
                                  LANE_W))
        : ram_rd_data;

endmodule

// File: rtl/ram_read_stream.sv
// Valid/ready read front-end for a single-cycle-latency synchronous RAM read
// port. Requests become rd_en/rd_addr pulses; read data returning one cycle
// later is either handed straight to the consumer or parked in a 2-entry
// response buffer so backpressure never drops a word.
// Optional feature: define RAM_READ_STREAM_FORWARD_EN to merge same-cycle
// write data into colliding reads.
module ram_read_stream
    import ram_read_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    input  logic                  snoop_wr_en,
    input  logic [MASK_WIDTH-1:0] snoop_wr_mask,
    input  logic [ADDR_WIDTH-1:0] snoop_wr_addr,
    input  logic [DATA_WIDTH-1:0] snoop_wr_data
);

    count_t                count;
    logic                  inflight;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

    logic                  fire;
    logic                  pop;
    logic                  pop_buf;
    logic                  push;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] cap_data;

`ifdef RAM_READ_STREAM_FORWARD_EN
    ram_read_stream_fwd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_fwd (
        .clk           (clk),
        .reset_n       (reset_n),
        .fire          (fire),
        .req_addr      (req_addr),
        .snoop_wr_en   (snoop_wr_en),
        .snoop_wr_mask (snoop_wr_mask),
        .snoop_wr_addr (snoop_wr_addr),
        .snoop_wr_data (snoop_wr_data),
        .ram_rd_data   (ram_rd_data),
        .merged        (cap_data)
    );
`else
    // Without forwarding the snoop port is intentionally ignored; colliding
    // lanes simply return whatever the RAM produced.
    logic unused_snoop;
    assign unused_snoop = ^{snoop_wr_en, snoop_wr_mask, snoop_wr_addr, snoop_wr_data};
    assign cap_data     = ram_rd_data;
`endif

    // A response is available from the buffer or from the read returning now.
    assign rsp_valid = (count != 2'd0) || inflight;
    assign rsp_data  = (count != 2'd0) ? buf_mem[rd_ptr] : cap_data;
    assign pop       = rsp_valid && rsp_ready;
    assign pop_buf   = pop && (count != 2'd0);

    // The returning word is parked unless the consumer takes it on the
    // bypass path this very cycle.
    assign push = inflight && !((count == 2'd0) && pop);

    // Slots committed after this edge; counting this cycle's pop lets a new
    // request in every cycle while the consumer keeps up.
    assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
    assign req_ready = !flush && (occupancy < 3'(BUF_DEPTH));

    assign fire        = req_valid && req_ready;
    assign ram_rd_en   = fire;
    assign ram_rd_addr = req_addr;

    // Control state: occupancy, in-flight flag and ring pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= fire;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + count_t'(push) - count_t'(pop_buf);
        end
    end

    // Buffer storage; contents are meaningful only while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= cap_data;
        end
    end

endmodule

// File: tb/tb_ram_read_stream.sv
// Directed self-checking bench for ram_read_stream with a behavioural
// single-cycle-latency RAM attached to the read and snoop ports.
module tb_ram_read_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        ram_rd_en;
    logic [9:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        snoop_wr_en;
    logic [3:0]  snoop_wr_mask;
    logic [9:0]  snoop_wr_addr;
    logic [31:0] snoop_wr_data;

    logic [31:0] mem [1024];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_read_stream #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .MASK_WIDTH (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .snoop_wr_en   (snoop_wr_en),
        .snoop_wr_mask (snoop_wr_mask),
        .snoop_wr_addr (snoop_wr_addr),
        .snoop_wr_data (snoop_wr_data)
    );

    // RAM model: read returns the pre-write word; rd_data is garbage on idle
    // cycles so the DUT cannot lean on the RAM holding its output.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        else           ram_rd_data <= 32'hDEAD_BEEF;
        if (snoop_wr_en) begin
            for (int l = 0; l < 4; l++)
                if (snoop_wr_mask[l]) mem[snoop_wr_addr][l*8 +: 8] = snoop_wr_data[l*8 +: 8];
        end
    end

    function automatic logic [31:0] exp_word(input int a);
        return 32'(a) * 32'h0101_0101;
    endfunction

    task automatic idle_inputs();
        flush = 0; req_valid = 0; req_addr = '0; rsp_ready = 0;
        snoop_wr_en = 0; snoop_wr_mask = '0; snoop_wr_addr = '0; snoop_wr_data = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        @(negedge clk); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", ram_rd_en); end
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_inputs();
            req_valid = (i < 8); req_addr = 10'(i); rsp_ready = 1;
            #1;
            if (i < 8) begin
                vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_req_ready[%0d]: got %b want 1", i, req_ready); end
            end
            vectors++; if (ram_rd_en !== (i < 8)) begin miscompares++; $display("FAIL b2b_rd_en[%0d]: got %b want %b", i, ram_rd_en, (i < 8)); end
            if (i >= 1 && i <= 8) begin
                vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
                vectors++; if (rsp_data !== exp_word(i - 1)) begin miscompares++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", i, rsp_data, exp_word(i - 1)); end
            end else begin
                vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_rsp_idle[%0d]: got %b want 0", i, rsp_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        // Per cycle: req_valid, addr, rsp_ready, expected req_ready, rsp_valid, rsp_data
        logic        v_in  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int          a_in  [8] = '{1, 2, 3, 3, 3, 0, 0, 0};
        logic        r_in  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic        e_rdy [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic        e_val [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] e_dat [8] = '{0, 32'h01010101, 32'h01010101, 32'h01010101,
                                   32'h01010101, 32'h02020202, 32'h03030303, 0};
        int accepted = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            req_valid = v_in[i]; req_addr = 10'(a_in[i]); rsp_ready = r_in[i];
            #1;
            vectors++; if (req_ready !== e_rdy[i]) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b want %b", i, req_ready, e_rdy[i]); end
            vectors++; if (rsp_valid !== e_val[i]) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b want %b", i, rsp_valid, e_val[i]); end
            if (e_val[i]) begin
                vectors++; if (rsp_data !== e_dat[i]) begin miscompares++; $display("FAIL bp_rsp_data[%0d]: got %h want %h", i, rsp_data, e_dat[i]); end
            end
            if (ram_rd_en) accepted++;
            if (i == 3) begin
                vectors++; if (accepted != 2) begin miscompares++; $display("FAIL bp_accepts_stalled: got %0d want 2", accepted); end
            end
        end
    endtask

    task automatic test_push_pop();
        logic [19:0] stall = 20'b1011_0110_1101_1010_0111;
        logic [31:0] exp_q [$];
        int          next_addr = 20;
        logic        exp_rdy;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            idle_inputs();
            req_valid = (i < 20); req_addr = 10'(next_addr);
            rsp_ready = (i < 20) ? stall[i] : 1'b1;
            #1;
            vectors++; if (rsp_valid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL pp_rsp_valid[%0d]: got %b want %b", i, rsp_valid, (exp_q.size() != 0)); end
            exp_rdy = ((exp_q.size() - ((exp_q.size() != 0 && rsp_ready) ? 1 : 0)) < 2);
            vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL pp_req_ready[%0d]: got %b want %b", i, req_ready, exp_rdy); end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                vectors++; if (rsp_data !== exp_q[0]) begin miscompares++; $display("FAIL pp_rsp_data[%0d]: got %h want %h", i, rsp_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (ram_rd_en) begin
                exp_q.push_back(exp_word(next_addr));
                next_addr++;
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL pp_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        @(negedge clk); idle_inputs(); req_valid = 1; req_addr = 10'd1;
        @(negedge clk); req_addr = 10'd2;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fl_setup_ready: got %b want 1", req_ready); end
        @(negedge clk); flush = 1; req_addr = 10'd7;
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL fl_req_ready_during: got %b want 0", req_ready); end
        vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL fl_rd_en_during: got %b want 0", ram_rd_en); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL fl_rsp_valid_during: got %b want 1", rsp_valid); end
        @(negedge clk); idle_inputs();
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fl_rsp_valid_after: got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fl_req_ready_after: got %b want 1", req_ready); end
        @(negedge clk); req_valid = 1; req_addr = 10'd5; rsp_ready = 1;
        @(negedge clk); req_valid = 0;
        #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL fl_new_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_data !== 32'h05050505) begin miscompares++; $display("FAIL fl_new_data: got %h want 05050505", rsp_data); end
        @(negedge clk); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fl_no_stale: got %b want 0", rsp_valid); end
    endtask

    task automatic test_forwarding();
        logic [31:0] chk_mask;
        logic [31:0] want;
`ifdef RAM_READ_STREAM_FORWARD_EN
        chk_mask = 32'hFFFF_FFFF;
`else
        chk_mask = 32'hFF00_FF00;
`endif
        want = 32'h04BB04DD;
        @(negedge clk); idle_inputs();
        req_valid = 1; req_addr = 10'd4; rsp_ready = 1;
        snoop_wr_en = 1; snoop_wr_mask = 4'b0101; snoop_wr_addr = 10'd4; snoop_wr_data = 32'hAABBCCDD;
        #1;
        vectors++; if (ram_rd_en !== 1'b1) begin miscompares++; $display("FAIL fwd_rd_en: got %b want 1", ram_rd_en); end
        // A write one cycle after the read must not leak into it.
        @(negedge clk); req_valid = 0;
        snoop_wr_en = 1; snoop_wr_mask = 4'hF; snoop_wr_addr = 10'd4; snoop_wr_data = 32'h11111111;
        #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if ((rsp_data & chk_mask) !== (want & chk_mask)) begin miscompares++; $display("FAIL fwd_rsp_data: got %h want %h (lanes %h)", rsp_data, want, chk_mask); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk); idle_inputs(); req_valid = 1; req_addr = 10'd10;
        @(negedge clk); req_addr = 10'd11;
        @(negedge clk); req_addr = 10'd12;
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ar_full_before: got %b want 0", req_ready); end
        #2; reset_n = 0; req_valid = 0;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ar_req_ready: got %b want 1", req_ready); end
        vectors++; if (ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL ar_rd_en: got %b want 0", ram_rd_en); end
        @(negedge clk); #1; reset_n = 1; rsp_ready = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_stale[%0d]: got %b want 0", i, rsp_valid); end
        end
        @(negedge clk); req_valid = 1; req_addr = 10'd12;
        @(negedge clk); req_valid = 0;
        #1;
        vectors++; if (rsp_data !== 32'h0C0C0C0C || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ar_new_rsp: got %b/%h want 1/0c0c0c0c", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_single: got %b want 0", rsp_valid); end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = exp_word(a);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_forwarding();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
